vga_address_decoder: RTL and testbench

//  Maps the VGA timing counters (hcnt, vcnt) to a 32-bit byte address in video memory, one byte per pixel.
//  A fixed-size image window sits at a programmable offset inside the 640x480 active area.

---
 rtl/vga_address_decoder.sv | 82 ++++++++
 tb/tb_vga_address_decoder.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/vga_address_decoder.sv
// Frame-buffer address generator: maps VGA (hcnt, vcnt) onto a fixed-size image window
// and produces a registered byte address plus an in-window flag, one pixel per clock.
module vga_address_decoder #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned IMG_W    = 256,
    parameter int unsigned IMG_H    = 256,
    parameter int unsigned H_OFFSET = 192,
    parameter int unsigned V_OFFSET = 112,
    parameter logic [31:0] BASE0    = 32'h0000_0000,
    parameter logic [31:0] BASE1    = 32'h0001_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        image_select,
    input  logic [9:0]  hcnt,
    input  logic [9:0]  vcnt,
    output logic [31:0] video_address,
    output logic        in_image
);

    localparam logic [31:0] H_START = 32'(H_OFFSET);
    localparam logic [31:0] V_START = 32'(V_OFFSET);
    localparam logic [31:0] H_END   = 32'(H_OFFSET + IMG_W);
    localparam logic [31:0] V_END   = 32'(V_OFFSET + IMG_H);
    localparam logic [31:0] H_LIMIT = 32'(H_ACTIVE);
    localparam logic [31:0] V_LIMIT = 32'(V_ACTIVE);
    localparam logic [31:0] ROW_PITCH = 32'(IMG_W);

    logic        r_sel_latched;
    logic [31:0] r_video_address;
    logic        r_in_image;

    logic [31:0] w_h_ext;
    logic [31:0] w_v_ext;
    logic        w_frame_start;
    logic        w_h_hit;
    logic        w_v_hit;
    logic        w_hit;
    logic [31:0] w_base;
    logic [31:0] w_next_address;

    assign w_h_ext       = {22'd0, hcnt};
    assign w_v_ext       = {22'd0, vcnt};
    assign w_frame_start = (hcnt == 10'd0) && (vcnt == 10'd0);

    assign w_h_hit = (w_h_ext >= H_START) && (w_h_ext < H_END) && (w_h_ext < H_LIMIT);
    assign w_v_hit = (w_v_ext >= V_START) && (w_v_ext < V_END) && (w_v_ext < V_LIMIT);
    assign w_hit   = w_h_hit && w_v_hit;

    // Base comes from the pre-edge latch, so the frame-start pixel still sees the old image.
    assign w_base = r_sel_latched ? BASE1 : BASE0;

    always_comb begin
        // NOTE: default first so every path assigns the signal and no latch is inferred.
        w_next_address = w_base;
        if (w_hit) begin
            w_next_address = w_base
                           + (w_v_ext - V_START) * ROW_PITCH
                           + (w_h_ext - H_START);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sel_latched   <= 1'b0;
            r_video_address <= 32'd0;
            r_in_image      <= 1'b0;
        end else begin
            // NOTE: non-blocking so all state samples pre-edge values, matching the hardware.
            if (w_frame_start) begin
                r_sel_latched <= image_select;
            end
            r_video_address <= w_next_address;
            r_in_image      <= w_hit;
        end
    end

    assign video_address = r_video_address;
    assign in_image      = r_in_image;

endmodule

// File: tb/tb_vga_address_decoder.sv
// Directed plus randomized checks of vga_address_decoder against a plain-arithmetic pixel model.
module tb_vga_address_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        image_select;
    logic [9:0]  hcnt;
    logic [9:0]  vcnt;
    logic [31:0] video_address;
    logic        in_image;

    int n_cmp = 0;
    int n_err = 0;
    bit m_sel = 1'b0;

    always #5 clk = ~clk;

    vga_address_decoder dut (
        .clk           (clk),
        .reset         (reset),
        .image_select  (image_select),
        .hcnt          (hcnt),
        .vcnt          (vcnt),
        .video_address (video_address),
        .in_image      (in_image)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Pixel model: 256x256 window at (192,112) inside 640x480, one byte per pixel.
    function automatic void ref_out(input bit sel, input int h, input int v,
                                    output logic [31:0] a, output logic hit);
        int unsigned base;
        base = sel ? 32'h0001_0000 : 32'h0000_0000;
        hit  = (h >= 192) && (h < 448) && (v >= 112) && (v < 368) && (h < 640) && (v < 480);
        a    = hit ? base + 32'((v - 112) * 256 + (h - 192)) : base;
    endfunction

    // Drives one counter pair, advances one clock, returns the model's expectation.
    task automatic cycle(input int h, input int v, input bit sel,
                         output logic [31:0] ea, output logic eh);
        hcnt         = 10'(h);
        vcnt         = 10'(v);
        image_select = sel;
        ref_out(m_sel, h, v, ea, eh);
        if (h == 0 && v == 0) m_sel = sel;
        @(posedge clk);
        #1;
    endtask

    task automatic step_lit(input string tag, input int h, input int v, input bit sel,
                            input logic [31:0] exp_a, input logic exp_h);
        logic [31:0] ea;
        logic        eh;
        cycle(h, v, sel, ea, eh);
        check({tag, "_addr"}, video_address, exp_a);
        check({tag, "_in"}, 32'(in_image), 32'(exp_h));
    endtask

    task automatic step_model(input string tag, input int h, input int v, input bit sel);
        logic [31:0] ea;
        logic        eh;
        cycle(h, v, sel, ea, eh);
        check({tag, "_addr"}, video_address, ea);
        check({tag, "_in"}, 32'(in_image), 32'(eh));
    endtask

    initial begin
        logic [31:0] ea;
        logic        eh;
        logic [31:0] prev_addr;
        logic        prev_in;
        int          h;
        int          v;
        int          line_hits;

        // Reset held with an in-window pixel on the counters.
        reset        = 1'b0;
        hcnt         = 10'd300;
        vcnt         = 10'd200;
        image_select = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("rst_addr", video_address, 32'h0);
            check("rst_in", 32'(in_image), 32'h0);
        end
        reset = 1'b1;
        m_sel = 1'b0;

        step_lit("first_px", 192, 112, 0, 32'h0000_0000, 1'b1);
        step_lit("last_px",  447, 367, 0, 32'h0000_FFFF, 1'b1);
        step_lit("h_past",   448, 367, 0, 32'h0000_0000, 1'b0);
        step_lit("h_before", 191, 200, 0, 32'h0000_0000, 1'b0);
        step_lit("v_past",   300, 368, 0, 32'h0000_0000, 1'b0);
        step_lit("v_before", 300, 111, 0, 32'h0000_0000, 1'b0);

        // Mid-frame select change must not take effect until the frame-start edge.
        step_lit("mid_sel",  300, 200, 1, 32'h0000_586C, 1'b1);
        step_lit("frame0",   0,   0,   1, 32'h0000_0000, 1'b0);
        step_lit("img1_px",  192, 112, 1, 32'h0001_0000, 1'b1);
        step_lit("img1_end", 447, 367, 1, 32'h0001_FFFF, 1'b1);
        step_lit("img1_miss", 900, 600, 0, 32'h0001_0000, 1'b0);

        // Free-running counters over lines 110..115 with image 0 latched.
        step_lit("frame_s0", 0, 0, 0, 32'h0001_0000, 1'b0);
        h = 0;
        v = 110;
        line_hits = 0;
        prev_in = 1'b0;
        prev_addr = 32'h0;
        for (int n = 0; n < 600 * 6; n++) begin
            cycle(h, v, 0, ea, eh);
            check("fr_addr", video_address, ea);
            check("fr_in", 32'(in_image), 32'(eh));
            if (in_image) line_hits++;
            if (prev_in && in_image) check("fr_incr", video_address, prev_addr + 32'd1);
            if (h == 192 && v >= 112 && v < 368)
                check("fr_linestart", video_address, 32'((v - 112) * 256));
            prev_in = in_image;
            prev_addr = video_address;
            h++;
            if (h == 600) begin
                check("fr_line_hits", 32'(line_hits), (v >= 112 && v < 368) ? 32'd256 : 32'd0);
                line_hits = 0;
                h = 0;
                v = (v + 1) % 400;
            end
        end

        // Wrap through the frame start with image 1 requested.
        h = 590;
        v = 399;
        for (int n = 0; n < 30; n++) begin
            step_model("wrap", h, v, 1);
            h++;
            if (h == 600) begin
                h = 0;
                v = (v + 1) % 400;
            end
        end

        // Random counter jumps, mostly around the window, occasional frame starts.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 15) == 0) begin
                h = 0;
                v = 0;
            end else if ($urandom_range(0, 1) == 1) begin
                h = int'($urandom_range(180, 460));
                v = int'($urandom_range(100, 380));
            end else begin
                h = int'($urandom_range(0, 1023));
                v = int'($urandom_range(0, 1023));
            end
            step_model("rand", h, v, 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset between edges while image 1 is displayed.
        step_lit("pre_rst_f", 0, 0, 1, (m_sel ? 32'h0001_0000 : 32'h0), 1'b0);
        step_lit("pre_rst",   300, 200, 1, 32'h0001_586C, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check("arst_addr", video_address, 32'h0);
        check("arst_in", 32'(in_image), 32'h0);
        @(posedge clk);
        #1;
        check("arst_hold_addr", video_address, 32'h0);
        reset = 1'b1;
        m_sel = 1'b0;
        step_lit("post_rst",   192, 112, 1, 32'h0000_0000, 1'b1);
        step_lit("post_rst2",  300, 200, 1, 32'h0000_586C, 1'b1);
        step_lit("post_frame", 0,   0,   1, 32'h0000_0000, 1'b0);
        step_lit("post_img1",  192, 112, 1, 32'h0001_0000, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
